// File: rtl/periodic_sync_gen_pkg.sv
// Shared definitions for the periodic sync generator.
// Holds the FSM state encodings, counter widths and the phase-width helper.
package periodic_sync_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int unsigned OFFSET_CNT_W = 16;
    localparam int unsigned RESYNC_CNT_W = 16;

    // Bits needed to hold 0..period-1, never less than 1.
    function automatic int unsigned phase_bits(input int unsigned period);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(period)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/periodic_sync_gen_phase_ctr.sv
// Wrap-at-PERIOD phase counter with the sync pulse-window compare.
// clr has priority and zeroes phase and pulse; start reloads phase 0 and
// opens a fresh pulse window; en advances the phase by one with wrap.
module periodic_sync_gen_phase_ctr #(
    parameter int unsigned PERIOD     = 128,
    parameter int unsigned PULSE_LEN  = 1,
    parameter int unsigned PHASE_BITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  en,
    output logic [PHASE_BITS-1:0] phase,
    output logic                  pulse
);

    localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(PERIOD - 1);
    localparam logic [PHASE_BITS-1:0] PULSE_END  = PHASE_BITS'(PULSE_LEN);

    logic [PHASE_BITS-1:0] phase_next;

    // Next phase: zero on start or at the end of the period, else +1.
    always_comb begin
        phase_next = phase + PHASE_BITS'(1);
        if (start || (phase == PHASE_LAST)) begin
            phase_next = '0;
        end
    end

    // Phase register and registered pulse-window compare on the next phase.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            phase <= '0;
            pulse <= 1'b0;
        end else if (start || en) begin
            phase <= phase_next;
            pulse <= (phase_next < PULSE_END);
        end
    end

endmodule

// File: rtl/periodic_sync_gen.sv
// Periodic sync source: arm, then trigger, then after OFFSET clocks emit a
// sync pulse every PERIOD clocks together with the running phase.
// Optional feature macro: PERIODIC_SYNC_GEN_RETRIG_EN (trig in RUN re-aligns
// the sequence and adds the resync_cnt output).
module periodic_sync_gen
    import periodic_sync_gen_pkg::*;
#(
    parameter  int unsigned PERIOD     = 128,
    parameter  int unsigned PULSE_LEN  = 1,
    parameter  int unsigned OFFSET     = 0,
    localparam int unsigned PHASE_BITS = phase_bits(PERIOD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic                    trig,
    output logic                    sync_out,
    output logic [PHASE_BITS-1:0]   phase,
    output logic                    armed,
`ifdef PERIODIC_SYNC_GEN_RETRIG_EN
    output logic [RESYNC_CNT_W-1:0] resync_cnt,
`endif
    output logic                    running
);

    if (PERIOD < 2 || PULSE_LEN < 1 || PULSE_LEN >= PERIOD || OFFSET > 65535)
    begin : g_bad_params
        $error("periodic_sync_gen: illegal PERIOD/PULSE_LEN/OFFSET");
    end

    localparam logic [OFFSET_CNT_W-1:0] OFFSET_LAST =
        (OFFSET > 0) ? OFFSET_CNT_W'(OFFSET - 1) : '0;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [OFFSET_CNT_W-1:0] offset_cnt;
    logic                    start_run;
`ifdef PERIODIC_SYNC_GEN_RETRIG_EN
    logic                    retrig;
`endif

    // Next-state decode; disarm dominates every other request.
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
`ifdef PERIODIC_SYNC_GEN_RETRIG_EN
        retrig     = 1'b0;
`endif
        if (disarm) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig) begin
                        if (OFFSET > 0) begin
                            state_next = ST_DELAY;
                        end else begin
                            state_next = ST_RUN;
                            start_run  = 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (offset_cnt == OFFSET_LAST) begin
                        state_next = ST_RUN;
                        start_run  = 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef PERIODIC_SYNC_GEN_RETRIG_EN
                    if (trig) begin
                        start_run = 1'b1;
                        retrig    = 1'b1;
                    end
`endif
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register with status flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            armed   <= (state_next == ST_ARMED);
            running <= (state_next == ST_DELAY) || (state_next == ST_RUN);
        end
    end

    // Offset counter: counts only while staying in DELAY, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_cnt <= '0;
        end else if ((state == ST_DELAY) && (state_next == ST_DELAY)) begin
            offset_cnt <= offset_cnt + OFFSET_CNT_W'(1);
        end else begin
            offset_cnt <= '0;
        end
    end

`ifdef PERIODIC_SYNC_GEN_RETRIG_EN
    // Saturating count of honoured re-triggers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resync_cnt <= '0;
        end else if (retrig && (resync_cnt != '1)) begin
            resync_cnt <= resync_cnt + RESYNC_CNT_W'(1);
        end
    end
`endif

    periodic_sync_gen_phase_ctr #(
        .PERIOD    (PERIOD),
        .PULSE_LEN (PULSE_LEN),
        .PHASE_BITS(PHASE_BITS)
    ) u_phase_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_next != ST_RUN),
        .start(start_run),
        .en   (state == ST_RUN),
        .phase(phase),
        .pulse(sync_out)
    );

endmodule
